// File: rtl/spike_popcount_scheduler_if.sv
// Requester, shared-pipeline and row-result signals of the spike popcount scheduler.
// master = surrounding datapath, slave = scheduler.
interface spike_popcount_scheduler_if #(
  parameter int REQ_NUM = 4,
  parameter int ID_W    = 2,
  parameter int ACC_W   = 16,
  // a full 32-bit spike word counts 0..32, so the return needs six bits
  parameter int SUM_W   = 6
);
  logic [REQ_NUM*32-1:0] i_req_data;
  logic [REQ_NUM-1:0]    i_req_valid;
  logic [REQ_NUM-1:0]    i_req_last;
  logic [REQ_NUM-1:0]    o_req_ready;
  logic [31:0]           o_pa_data;
  logic                  o_pa_valid;
  logic [SUM_W-1:0]      i_pa_sum;
  logic                  i_pa_sum_valid;
  logic                  i_clear;
  logic [ACC_W-1:0]      o_row_sum;
  logic [ID_W-1:0]       o_row_id;
  logic                  o_row_valid;
  logic                  o_err;
  logic                  o_busy;

  modport master (
    output i_req_data, i_req_valid, i_req_last, i_pa_sum, i_pa_sum_valid, i_clear,
    input  o_req_ready, o_pa_data, o_pa_valid, o_row_sum, o_row_id, o_row_valid, o_err, o_busy
  );

  modport slave (
    input  i_req_data, i_req_valid, i_req_last, i_pa_sum, i_pa_sum_valid, i_clear,
    output o_req_ready, o_pa_data, o_pa_valid, o_row_sum, o_row_id, o_row_valid, o_err, o_busy
  );
endinterface

// File: rtl/spike_popcount_scheduler.sv
// Round-robin share of one popcount pipeline among REQ_NUM row streams; per-requester row sums.
// Latency: word handshake t -> o_pa_valid t+1 -> o_row_valid t+1+PA_LAT+1 for a last word.
// Backpressure: o_req_ready one-hot grant from valid; SPIKE_SCHED_ROW_LOCK_EN holds grant for a whole row.
module spike_popcount_scheduler #(
  parameter int REQ_NUM = 4,
  parameter int ID_W    = 2,
  parameter int ACC_W   = 16,
  parameter int PA_LAT  = 3
) (
  input logic s_clk,
  input logic s_rst_n,
  spike_popcount_scheduler_if.slave bus
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            last;
  } tag_t;

  logic                  run_q;
  logic [ID_W-1:0]       rr_ptr;
  logic [REQ_NUM-1:0]    ready;
  logic                  hs;
  logic                  hs_last;
  logic [ID_W-1:0]       hs_id;
  logic [31:0]           hs_word;
  logic                  lock_active;
  logic [ID_W-1:0]       lock_id;

  tag_t [PA_LAT:0]       tag_pipe;
  tag_t                  ret_tag;
  logic                  ret_ok;
  logic [ACC_W-1:0]      acc [REQ_NUM];
  logic [ACC_W:0]        sum_raw;
  logic [ACC_W-1:0]      sum_sat;

  logic [31:0]           pa_data_q;
  logic                  pa_valid_q;
  logic [ACC_W-1:0]      row_sum_q;
  logic [ID_W-1:0]       row_id_q;
  logic                  row_valid_q;
  logic                  err_q;
  logic                  busy;

`ifdef SPIKE_SCHED_ROW_LOCK_EN
  typedef enum logic {LK_IDLE = 1'b0, LK_LOCKED = 1'b1} lock_st_t;

  lock_st_t        lock_st, lock_nxt;
  logic [ID_W-1:0] lock_id_q, lock_id_nxt;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      lock_st   <= LK_IDLE;
      lock_id_q <= '0;
    end else begin
      lock_st   <= lock_nxt;
      lock_id_q <= lock_id_nxt;
    end
  end

  always_comb begin
    lock_nxt    = lock_st;
    lock_id_nxt = lock_id_q;
    if (bus.i_clear) begin
      lock_nxt = LK_IDLE;
    end else begin
      case (lock_st)
        LK_IDLE: if (hs && !hs_last) begin
          lock_nxt    = LK_LOCKED;
          lock_id_nxt = hs_id;
        end
        LK_LOCKED: if (hs && hs_last) lock_nxt = LK_IDLE;
        default: lock_nxt = LK_IDLE;
      endcase
    end
  end

  always_comb begin
    lock_active = (lock_st == LK_LOCKED);
    lock_id     = lock_id_q;
  end
`else
  assign lock_active = 1'b0;
  assign lock_id     = '0;
`endif

  // Grant search from rr_ptr with wrap; lock narrows it to the owning requester.
  // Clear also blocks grants so no word is issued without a tag.
  always_comb begin
    logic           found;
    logic [ID_W:0]  pos;
    logic [ID_W-1:0] idx;
    ready = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      pos = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (pos >= (ID_W+1)'(REQ_NUM)) pos = pos - (ID_W+1)'(REQ_NUM);
      idx = pos[ID_W-1:0];
      if (!found && bus.i_req_valid[idx]) begin
        found      = 1'b1;
        ready[idx] = 1'b1;
      end
    end
    if (lock_active) begin
      ready          = '0;
      ready[lock_id] = bus.i_req_valid[lock_id];
    end
    if (!run_q || bus.i_clear) ready = '0;
  end

  always_comb begin
    hs      = |ready;
    hs_last = |(ready & bus.i_req_last);
    hs_id   = '0;
    hs_word = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (ready[k]) begin
        hs_id   = ID_W'(k);
        hs_word = bus.i_req_data[32*k +: 32];
      end
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      run_q      <= 1'b0;
      rr_ptr     <= '0;
      pa_valid_q <= 1'b0;
      pa_data_q  <= '0;
    end else begin
      run_q      <= 1'b1;
      pa_valid_q <= hs;
      if (hs) begin
        pa_data_q <= hs_word;
        rr_ptr    <= (hs_id == ID_W'(REQ_NUM-1)) ? '0 : hs_id + 1'b1;
      end
    end
  end

  // Tag stage PA_LAT lines up with the pipeline return of the same word.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tag_pipe <= '0;
    end else if (bus.i_clear) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe <= {tag_pipe[PA_LAT-1:0], tag_t'{vld: hs, id: hs_id, last: hs_last}};
    end
  end

  assign ret_tag = tag_pipe[PA_LAT];
  assign ret_ok  = bus.i_pa_sum_valid && ret_tag.vld;
  assign sum_raw = {1'b0, acc[ret_tag.id]} + (ACC_W+1)'(bus.i_pa_sum);
  assign sum_sat = sum_raw[ACC_W] ? '1 : sum_raw[ACC_W-1:0];

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int k = 0; k < REQ_NUM; k++) acc[k] <= '0;
      row_sum_q   <= '0;
      row_id_q    <= '0;
      row_valid_q <= 1'b0;
    end else if (bus.i_clear) begin
      for (int k = 0; k < REQ_NUM; k++) acc[k] <= '0;
      row_valid_q <= 1'b0;
    end else begin
      row_valid_q <= ret_ok && ret_tag.last;
      if (ret_ok) begin
        if (ret_tag.last) begin
          row_sum_q        <= sum_sat;
          row_id_q         <= ret_tag.id;
          acc[ret_tag.id]  <= '0;
        end else begin
          acc[ret_tag.id]  <= sum_sat;
        end
      end
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      err_q <= 1'b0;
    end else if (bus.i_pa_sum_valid != ret_tag.vld) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= PA_LAT; i++) busy = busy | tag_pipe[i].vld;
    for (int k = 0; k < REQ_NUM; k++) busy = busy | (acc[k] != '0);
  end

  assign bus.o_req_ready = ready;
  assign bus.o_pa_data   = pa_data_q;
  assign bus.o_pa_valid  = pa_valid_q;
  assign bus.o_row_sum   = row_sum_q;
  assign bus.o_row_id    = row_id_q;
  assign bus.o_row_valid = row_valid_q;
  assign bus.o_err       = err_q;
  assign bus.o_busy      = busy;

endmodule

// File: tb/tb_spike_popcount_scheduler.sv
// Directed bench: behavioural 3-cycle popcount pipeline plus per-scenario tasks with inline checks.
module tb_spike_popcount_scheduler;
  localparam int REQ_NUM = 4;
  localparam int ID_W    = 2;
  localparam int ACC_W   = 16;
  localparam int PA_LAT  = 3;

  logic s_clk = 1'b0;
  logic s_rst_n;
  always #5 s_clk = ~s_clk;

  spike_popcount_scheduler_if #(.REQ_NUM(REQ_NUM), .ID_W(ID_W), .ACC_W(ACC_W)) bus ();

  spike_popcount_scheduler #(
    .REQ_NUM(REQ_NUM), .ID_W(ID_W), .ACC_W(ACC_W), .PA_LAT(PA_LAT)
  ) dut (
    .s_clk  (s_clk),
    .s_rst_n(s_rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge s_clk) cyc <= cyc + 1;

  // Shared pipeline model: popcount returned PA_LAT cycles after o_pa_valid.
  logic [PA_LAT-1:0] pv;
  logic [5:0]        ps [PA_LAT];
  logic              inj = 1'b0;
  logic              drop = 1'b0;
  always @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      pv <= '0;
      for (int i = 0; i < PA_LAT; i++) ps[i] <= '0;
    end else begin
      pv    <= {pv[PA_LAT-2:0], bus.o_pa_valid};
      ps[0] <= 6'($countones(bus.o_pa_data));
      for (int i = 1; i < PA_LAT; i++) ps[i] <= ps[i-1];
    end
  end
  assign bus.i_pa_sum       = inj ? 6'd17 : ps[PA_LAT-1];
  assign bus.i_pa_sum_valid = (pv[PA_LAT-1] & ~drop) | inj;

  int rid_q[$];
  int rsum_q[$];
  int rcyc_q[$];
  always @(negedge s_clk) begin
    if (s_rst_n && bus.o_row_valid) begin
      rid_q.push_back(int'(bus.o_row_id));
      rsum_q.push_back(int'(bus.o_row_sum));
      rcyc_q.push_back(cyc);
    end
  end

  logic [31:0] wmem [REQ_NUM][2100];
  int wcnt [REQ_NUM];
  int wpos [REQ_NUM];
  int gq [64];
  int gcnt;
  int last_hs;
  int ohviol;

  task automatic idle_inputs();
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    bus.i_req_data  = '0;
    bus.i_clear     = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    inj = 1'b0;
    drop = 1'b0;
    s_rst_n = 1'b0;
    repeat (2) @(negedge s_clk);
    s_rst_n = 1'b1;
    rid_q.delete(); rsum_q.delete(); rcyc_q.delete();
    for (int k = 0; k < REQ_NUM; k++) begin wcnt[k] = 0; wpos[k] = 0; end
    ohviol = 0;
    repeat (2) @(negedge s_clk);
  endtask

  task automatic drive_rows(input int budget);
    int n = 0;
    bit pend = 1'b1;
    gcnt = 0;
    while (pend && n < budget) begin
      @(negedge s_clk);
      for (int k = 0; k < REQ_NUM; k++) begin
        bus.i_req_valid[k]        = (wpos[k] < wcnt[k]);
        bus.i_req_data[32*k +: 32] = wmem[k][wpos[k]];
        bus.i_req_last[k]         = (wpos[k] == wcnt[k] - 1);
      end
      #1;
      if ($countones(bus.o_req_ready) > 1) ohviol++;
      for (int k = 0; k < REQ_NUM; k++) begin
        if (bus.i_req_valid[k] && bus.o_req_ready[k]) begin
          if (gcnt < 64) gq[gcnt] = k;
          gcnt++;
          last_hs = cyc;
          wpos[k]++;
        end
      end
      pend = 1'b0;
      for (int k = 0; k < REQ_NUM; k++) if (wpos[k] < wcnt[k]) pend = 1'b1;
      n++;
    end
    @(negedge s_clk);
    idle_inputs();
    checks++;
    if (pend) begin failures++; $display("FAIL drive_timeout: words still pending after %0d cycles", budget); end
  endtask

  task automatic wait_rows(input int n, input int budget);
    int c = 0;
    while (rid_q.size() < n && c < budget) begin @(negedge s_clk); c++; end
    checks++;
    if (rid_q.size() < n) begin failures++; $display("FAIL row_timeout: got %0d rows required %0d", rid_q.size(), n); end
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0;
    bus.i_req_valid = '1;
    bus.i_req_data  = {REQ_NUM{32'hA5A5_5A5A}};
    bus.i_req_last  = '0;
    bus.i_clear     = 1'b0;
    #1;
    checks++; if (bus.o_req_ready !== '0) begin failures++; $display("FAIL rst_ready: got %0h required 0", bus.o_req_ready); end
    checks++; if (bus.o_pa_valid !== 1'b0) begin failures++; $display("FAIL rst_pa_valid: got %0b required 0", bus.o_pa_valid); end
    checks++; if (bus.o_pa_data !== 32'h0) begin failures++; $display("FAIL rst_pa_data: got %0h required 0", bus.o_pa_data); end
    checks++; if (bus.o_row_valid !== 1'b0) begin failures++; $display("FAIL rst_row_valid: got %0b required 0", bus.o_row_valid); end
    checks++; if (bus.o_row_sum !== '0) begin failures++; $display("FAIL rst_row_sum: got %0h required 0", bus.o_row_sum); end
    checks++; if (bus.o_row_id !== '0) begin failures++; $display("FAIL rst_row_id: got %0h required 0", bus.o_row_id); end
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %0b required 0", bus.o_err); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b required 0", bus.o_busy); end
  endtask

  task automatic test_single();
    apply_reset();
    wmem[0][0] = 32'hFFFF_FFFF; wmem[0][1] = 32'h0;
    wmem[0][2] = 32'h0000_000F; wmem[0][3] = 32'h8000_0001;
    wcnt[0] = 4;
    drive_rows(20);
    wait_rows(1, 20);
    checks++; if (rsum_q[0] !== 38) begin failures++; $display("FAIL single_sum: got %0d required 38", rsum_q[0]); end
    checks++; if (rid_q[0] !== 0) begin failures++; $display("FAIL single_id: got %0d required 0", rid_q[0]); end
    checks++; if (rcyc_q[0] - last_hs !== 5) begin failures++; $display("FAIL single_latency: got %0d required 5", rcyc_q[0] - last_hs); end
    checks++; if (gcnt !== 4) begin failures++; $display("FAIL single_grants: got %0d required 4", gcnt); end
    repeat (2) @(negedge s_clk);
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %0b required 0", bus.o_busy); end
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL single_err: got %0b required 0", bus.o_err); end
  endtask

  task automatic test_fairness();
    int exp_g [8];
    int exp_s [4];
    apply_reset();
    wmem[0][0] = 32'h0000_0001; wmem[0][1] = 32'h0000_0003;
    wmem[1][0] = 32'h0000_00FF; wmem[1][1] = 32'h0000_FFFF;
    wmem[2][0] = 32'hFFFF_FFFF; wmem[2][1] = 32'hF0F0_F0F0;
    wmem[3][0] = 32'h0000_0000; wmem[3][1] = 32'h8000_0000;
    exp_s = '{3, 24, 48, 1};
`ifdef SPIKE_SCHED_ROW_LOCK_EN
    exp_g = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int k = 0; k < REQ_NUM; k++) wcnt[k] = 2;
    drive_rows(30);
    wait_rows(4, 20);
    for (int i = 0; i < 8; i++) begin
      checks++; if (gq[i] !== exp_g[i]) begin failures++; $display("FAIL fair_grant[%0d]: got %0d required %0d", i, gq[i], exp_g[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rid_q[i] !== i) begin failures++; $display("FAIL fair_row_id[%0d]: got %0d required %0d", i, rid_q[i], i); end
      checks++; if (rsum_q[i] !== exp_s[i]) begin failures++; $display("FAIL fair_row_sum[%0d]: got %0d required %0d", i, rsum_q[i], exp_s[i]); end
    end
    checks++; if (ohviol !== 0) begin failures++; $display("FAIL fair_onehot: got %0d multi-grant cycles required 0", ohviol); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 2050; i++) wmem[2][i] = 32'hFFFF_FFFF;
    wcnt[2] = 2050;
    drive_rows(2200);
    wait_rows(1, 20);
    checks++; if (rsum_q[0] !== 65535) begin failures++; $display("FAIL sat_sum: got %0d required 65535", rsum_q[0]); end
    checks++; if (rid_q[0] !== 2) begin failures++; $display("FAIL sat_id: got %0d required 2", rid_q[0]); end
    wmem[2][0] = 32'h0000_0003; wcnt[2] = 1; wpos[2] = 0;
    drive_rows(10);
    wait_rows(2, 20);
    checks++; if (rsum_q[1] !== 2) begin failures++; $display("FAIL sat_next_row: got %0d required 2", rsum_q[1]); end
  endtask

  task automatic test_protocol_err();
    apply_reset();
    @(negedge s_clk); inj = 1'b1;
    @(negedge s_clk); inj = 1'b0;
    #1;
    checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL err_set: got %0b required 1", bus.o_err); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL err_acc_untouched: busy %0b required 0", bus.o_busy); end
    repeat (5) @(negedge s_clk);
    checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %0b required 1", bus.o_err); end
    checks++; if (rid_q.size() !== 0) begin failures++; $display("FAIL err_no_row: got %0d rows required 0", rid_q.size()); end
    wmem[1][0] = 32'h0000_0007; wcnt[1] = 1;
    drive_rows(10);
    wait_rows(1, 20);
    checks++; if (rsum_q[0] !== 3) begin failures++; $display("FAIL err_after_sum: got %0d required 3", rsum_q[0]); end
    checks++; if (rid_q[0] !== 1) begin failures++; $display("FAIL err_after_id: got %0d required 1", rid_q[0]); end
  endtask

  task automatic test_missing_return();
    apply_reset();
    drop = 1'b1;
    wmem[0][0] = 32'h0000_000F; wcnt[0] = 1;
    drive_rows(10);
    repeat (8) @(negedge s_clk);
    checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL miss_err: got %0b required 1", bus.o_err); end
    checks++; if (rid_q.size() !== 0) begin failures++; $display("FAIL miss_no_row: got %0d rows required 0", rid_q.size()); end
    drop = 1'b0;
  endtask

  task automatic test_clear();
    apply_reset();
    @(negedge s_clk);
    bus.i_req_valid[1] = 1'b1; bus.i_req_last[1] = 1'b0; bus.i_req_data[32 +: 32] = 32'h0000_00FF;
    @(negedge s_clk);
    idle_inputs();
    repeat (6) @(negedge s_clk);
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL clr_busy_before: got %0b required 1", bus.o_busy); end
    bus.i_clear = 1'b1;
    @(negedge s_clk);
    bus.i_clear = 1'b0;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL clr_busy_after: got %0b required 0", bus.o_busy); end
    wmem[1][0] = 32'h0000_0005; wcnt[1] = 1;
    drive_rows(10);
    wait_rows(1, 20);
    checks++; if (rsum_q[0] !== 2) begin failures++; $display("FAIL clr_row_sum: got %0d required 2", rsum_q[0]); end
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL clr_err: got %0b required 0", bus.o_err); end
  endtask

  task automatic test_reset_midrow();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge s_clk);
      bus.i_req_valid[3] = 1'b1; bus.i_req_last[3] = 1'b0; bus.i_req_data[96 +: 32] = 32'hFFFF_FFFF;
    end
    @(negedge s_clk);
    #2;
    s_rst_n = 1'b0;
    #1;
    checks++; if (bus.o_req_ready !== '0) begin failures++; $display("FAIL mid_ready: got %0h required 0", bus.o_req_ready); end
    checks++; if (bus.o_pa_valid !== 1'b0) begin failures++; $display("FAIL mid_pa_valid: got %0b required 0", bus.o_pa_valid); end
    checks++; if (bus.o_pa_data !== 32'h0) begin failures++; $display("FAIL mid_pa_data: got %0h required 0", bus.o_pa_data); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %0b required 0", bus.o_busy); end
    idle_inputs();
    repeat (2) @(negedge s_clk);
    s_rst_n = 1'b1;
    rid_q.delete(); rsum_q.delete(); rcyc_q.delete();
    repeat (2) @(negedge s_clk);
    wmem[3][0] = 32'h1; wmem[3][1] = 32'h3; wmem[3][2] = 32'h7; wmem[3][3] = 32'hF;
    wcnt[3] = 4; wpos[3] = 0;
    drive_rows(20);
    wait_rows(1, 20);
    checks++; if (rsum_q[0] !== 10) begin failures++; $display("FAIL mid_row_sum: got %0d required 10", rsum_q[0]); end
    checks++; if (rid_q[0] !== 3) begin failures++; $display("FAIL mid_row_id: got %0d required 3", rid_q[0]); end
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL mid_err: got %0b required 0", bus.o_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_saturation();
    test_protocol_err();
    test_missing_return();
    test_clear();
    test_reset_midrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
